// File: rtl/jogador_automatico_if.sv
// Button-side bus between the automatic player and the game.
// slave = the bot (sees game requests, drives buttons); master = game/testbench side.
interface jogador_automatico_if;
    logic       habilita;
    logic [1:0] jogador_bot;
    logic [1:0] jogador_atual;
    logic       jogar_macro;
    logic       jogar_micro;
    logic [8:0] disponiveis;
    logic [8:0] botoes;
    logic       jogada_feita;
    logic       erro_sem_jogada;
    logic [3:0] db_estado;

    modport slave (
        input  habilita,
        input  jogador_bot,
        input  jogador_atual,
        input  jogar_macro,
        input  jogar_micro,
        input  disponiveis,
        output botoes,
        output jogada_feita,
        output erro_sem_jogada,
        output db_estado
    );

    modport master (
        output habilita,
        output jogador_bot,
        output jogador_atual,
        output jogar_macro,
        output jogar_micro,
        output disponiveis,
        input  botoes,
        input  jogada_feita,
        input  erro_sem_jogada,
        input  db_estado
    );
endinterface

// File: rtl/jogador_automatico.sv
// Automatic opponent: waits, scans for a free position from a pseudo-random start,
// then drives a registered one-hot press/release on the 9-bit button bus.
module jogador_automatico #(
    parameter int DELAY_CYCLES = 16,
    parameter int PULSE_CYCLES = 4
) (
    input  logic              clock,
    input  logic              reset,
    jogador_automatico_if.slave bus
);
    localparam int DW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [DW-1:0] DELAY_LAST = DW'(DELAY_CYCLES - 1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        ESPERA     = 4'd1,
        BUSCA      = 4'd2,
        PRESSIONA  = 4'd3,
        SOLTA      = 4'd4,
        SEM_JOGADA = 4'd5
    } estado_t;

    estado_t         r_estado_reg,  w_estado_next;
    logic [3:0]      r_sorteio_reg, w_sorteio_next;
    logic [DW-1:0]   r_delay_reg,   w_delay_next;
    logic [3:0]      r_idx_reg,     w_idx_next;
    logic [3:0]      r_scan_reg,    w_scan_next;
    logic [3:0]      r_sel_reg,     w_sel_next;
    logic [PW-1:0]   r_pulse_reg,   w_pulse_next;
    logic            r_fase_reg,    w_fase_next;
    logic [8:0]      r_botoes_reg,  w_botoes_next;

    logic            w_bot_valido;
    logic            w_req;
    logic            w_livre;
    logic [8:0]      w_idx_onehot;
    logic [8:0]      w_sel_onehot;

    // Codes other than 01/10 must never match the current player.
    assign w_bot_valido = (bus.jogador_bot == 2'b01) || (bus.jogador_bot == 2'b10);
    assign w_req = bus.habilita && (bus.jogar_macro || bus.jogar_micro) &&
                   w_bot_valido && (bus.jogador_atual == bus.jogador_bot);

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_decode
            assign w_idx_onehot[gi] = (r_idx_reg == 4'(gi));
            assign w_sel_onehot[gi] = (r_sel_reg == 4'(gi));
        end
    endgenerate

    assign w_livre = |(bus.disponiveis & w_idx_onehot);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado_reg  <= IDLE;
            r_sorteio_reg <= '0;
            r_delay_reg   <= '0;
            r_idx_reg     <= '0;
            r_scan_reg    <= '0;
            r_sel_reg     <= '0;
            r_pulse_reg   <= '0;
            r_fase_reg    <= 1'b0;
            r_botoes_reg  <= '0;
        end else begin
            r_estado_reg  <= w_estado_next;
            r_sorteio_reg <= w_sorteio_next;
            r_delay_reg   <= w_delay_next;
            r_idx_reg     <= w_idx_next;
            r_scan_reg    <= w_scan_next;
            r_sel_reg     <= w_sel_next;
            r_pulse_reg   <= w_pulse_next;
            r_fase_reg    <= w_fase_next;
            r_botoes_reg  <= w_botoes_next;
        end
    end

    always_comb begin
        w_estado_next  = r_estado_reg;
        w_sorteio_next = (r_sorteio_reg == 4'd8) ? 4'd0 : r_sorteio_reg + 4'd1;
        w_delay_next   = r_delay_reg;
        w_idx_next     = r_idx_reg;
        w_scan_next    = r_scan_reg;
        w_sel_next     = r_sel_reg;
        w_pulse_next   = r_pulse_reg;
        w_fase_next    = r_fase_reg;
        w_botoes_next  = '0;

        case (r_estado_reg)
            IDLE: begin
                if (w_req) begin
                    w_fase_next   = bus.jogar_macro;
                    w_delay_next  = '0;
                    w_estado_next = ESPERA;
                end
            end
            ESPERA: begin
                if (!w_req) begin
                    w_estado_next = IDLE;
                end else if (r_delay_reg == DELAY_LAST) begin
                    w_idx_next    = r_sorteio_reg;
                    w_scan_next   = '0;
                    w_estado_next = BUSCA;
                end else begin
                    w_delay_next  = r_delay_reg + 1'b1;
                end
            end
            BUSCA: begin
                if (!w_req) begin
                    w_estado_next = IDLE;
                end else if (w_livre) begin
                    // Buttons are loaded on entry so they are high for every PRESSIONA cycle.
                    w_sel_next    = r_idx_reg;
                    w_botoes_next = w_idx_onehot;
                    w_pulse_next  = '0;
                    w_estado_next = PRESSIONA;
                end else if (r_scan_reg == 4'd8) begin
                    w_estado_next = SEM_JOGADA;
                end else begin
                    w_idx_next    = (r_idx_reg == 4'd8) ? 4'd0 : r_idx_reg + 4'd1;
                    w_scan_next   = r_scan_reg + 4'd1;
                end
            end
            PRESSIONA: begin
                if (r_pulse_reg == PULSE_LAST) begin
                    w_estado_next = SOLTA;
                end else begin
                    w_botoes_next = w_sel_onehot;
                    w_pulse_next  = r_pulse_reg + 1'b1;
                end
            end
            SOLTA: begin
                // A phase change (macro -> micro) releases without waiting for req to drop.
                if (!w_req || (bus.jogar_macro != r_fase_reg)) begin
                    w_estado_next = IDLE;
                end
            end
            SEM_JOGADA: begin
                if (!w_req) begin
                    w_estado_next = IDLE;
                end
            end
            default: begin
                w_estado_next = IDLE;
            end
        endcase
    end

    assign bus.botoes          = r_botoes_reg;
    assign bus.jogada_feita    = (r_estado_reg == PRESSIONA) && (r_pulse_reg == PULSE_LAST);
    assign bus.erro_sem_jogada = (r_estado_reg == SEM_JOGADA);
    assign bus.db_estado       = r_estado_reg;
endmodule
